// File: rtl/trainsim_pkg.sv
// Shared track-model definitions: motor encodings, sensor bit map, switch routes
// and default layout parameters used by the track model and its controller.
package trainsim_pkg;

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_FWD  = 2'b01;
   localparam logic [1:0] DIR_REV  = 2'b10;

   localparam int SENS_A_APP  = 0;
   localparam int SENS_B_APP  = 1;
   localparam int SENS_B_EXIT = 2;
   localparam int SENS_A_EXIT = 3;
   localparam int SENS_SPARE  = 4;
   localparam int SENS_W      = 5;

   localparam int DEF_LOOP_LEN = 16;
   localparam int DEF_SH_START = 4;
   localparam int DEF_SH_END   = 7;
   localparam int DEF_TICK_DIV = 4;
   localparam int DEF_A_INIT   = 0;
   localparam int DEF_B_INIT   = 10;

   typedef enum logic [1:0] {
      ROUTE_NONE = 2'b00,
      ROUTE_A    = 2'b01,
      ROUTE_B    = 2'b10
   } route_e;

   function automatic logic in_range(input int p, input int lo, input int hi);
      return (p >= lo) && (p <= hi);
   endfunction

endpackage

// File: rtl/train_mover.sv
// One train: position register with loop wrap, shared-segment entry check and
// a sticky derail flag that freezes the train until reset.
module train_mover
   import trainsim_pkg::*;
#(
   parameter int LOOP_LEN = DEF_LOOP_LEN,
   parameter int SH_START = DEF_SH_START,
   parameter int SH_END   = DEF_SH_END,
   parameter int INIT     = 0,
   parameter int PW       = $clog2(LOOP_LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_step,
   input  logic [1:0]    i_dir,
   input  logic          i_route_ok,
   output logic [PW-1:0] o_pos,
   output logic [PW-1:0] o_pos_nxt,
   output logic          o_derail
);

   // The two cells just outside the shared segment, wrapped onto the loop.
   localparam int APP_POS  = (SH_START + LOOP_LEN - 1) % LOOP_LEN;
   localparam int EXIT_POS = (SH_END + 1) % LOOP_LEN;

   logic [PW-1:0] r_pos;
   logic          r_derail;
   logic [PW-1:0] w_fwd;
   logic [PW-1:0] w_rev;
   logic [PW-1:0] w_pos_nxt;
   logic          w_derail_nxt;

   always_comb begin
      w_fwd        = (r_pos == PW'(LOOP_LEN - 1)) ? '0 : r_pos + PW'(1);
      w_rev        = (r_pos == '0) ? PW'(LOOP_LEN - 1) : r_pos - PW'(1);
      w_pos_nxt    = r_pos;
      w_derail_nxt = r_derail;
      if (i_step && !r_derail) begin
         case (i_dir)
            DIR_FWD: begin
               if (r_pos == PW'(APP_POS) && !i_route_ok) w_derail_nxt = 1'b1;
               else                                      w_pos_nxt    = w_fwd;
            end
            DIR_REV: begin
               if (r_pos == PW'(EXIT_POS) && !i_route_ok) w_derail_nxt = 1'b1;
               else                                       w_pos_nxt    = w_rev;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pos    <= PW'(INIT);
         r_derail <= 1'b0;
      end else begin
         r_pos    <= w_pos_nxt;
         r_derail <= w_derail_nxt;
      end
   end

   assign o_pos     = r_pos;
   assign o_pos_nxt = w_pos_nxt;
   assign o_derail  = r_derail;

endmodule

// File: rtl/train_track_model.sv
// Two-train loop with one switched shared segment: step timer, switch decode,
// registered approach/exit sensors and a sticky collision flag.
module train_track_model
   import trainsim_pkg::*;
#(
   parameter int LOOP_LEN = DEF_LOOP_LEN,
   parameter int SH_START = DEF_SH_START,
   parameter int SH_END   = DEF_SH_END,
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int A_INIT   = DEF_A_INIT,
   parameter int B_INIT   = DEF_B_INIT,
   localparam int PW      = $clog2(LOOP_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        sw,
   input  logic [1:0]        dira,
   input  logic [1:0]        dirb,
   output logic [SENS_W-1:0] sensor,
   output logic [PW-1:0]     pos_a,
   output logic [PW-1:0]     pos_b,
   output logic              derail_a,
   output logic              derail_b,
   output logic              collision
);

   localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int APP_POS  = (SH_START + LOOP_LEN - 1) % LOOP_LEN;
   localparam int EXIT_POS = (SH_END + 1) % LOOP_LEN;

   logic [TW-1:0]     r_tick;
   logic              w_step;
   route_e            w_route;
   logic              w_unused_sw;
   logic [PW-1:0]     w_a_nxt;
   logic [PW-1:0]     w_b_nxt;
   logic [SENS_W-1:0] r_sensor;
   logic [SENS_W-1:0] w_sensor_nxt;
   logic              r_coll;

   assign w_step      = (r_tick == TW'(TICK_DIV - 1));
   assign w_unused_sw = sw[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_tick <= '0;
      else if (w_step) r_tick <= '0;
      else             r_tick <= r_tick + TW'(1);
   end

   // Mixed switch points (01/10) route nowhere: any entry derails.
   always_comb begin
      w_route = ROUTE_NONE;
      case (sw[1:0])
         2'b00:   w_route = ROUTE_A;
         2'b11:   w_route = ROUTE_B;
         default: w_route = ROUTE_NONE;
      endcase
   end

   train_mover #(
      .LOOP_LEN (LOOP_LEN), .SH_START (SH_START), .SH_END (SH_END),
      .INIT     (A_INIT),   .PW       (PW)
   ) u_mover_a (
      .clk        (clk),
      .rst        (rst),
      .i_step     (w_step),
      .i_dir      (dira),
      .i_route_ok (w_route == ROUTE_A),
      .o_pos      (pos_a),
      .o_pos_nxt  (w_a_nxt),
      .o_derail   (derail_a)
   );

   train_mover #(
      .LOOP_LEN (LOOP_LEN), .SH_START (SH_START), .SH_END (SH_END),
      .INIT     (B_INIT),   .PW       (PW)
   ) u_mover_b (
      .clk        (clk),
      .rst        (rst),
      .i_step     (w_step),
      .i_dir      (dirb),
      .i_route_ok (w_route == ROUTE_B),
      .o_pos      (pos_b),
      .o_pos_nxt  (w_b_nxt),
      .o_derail   (derail_b)
   );

   always_comb begin
      w_sensor_nxt              = '0;
      w_sensor_nxt[SENS_A_APP]  = (pos_a == PW'(APP_POS));
      w_sensor_nxt[SENS_B_APP]  = (pos_b == PW'(APP_POS));
      w_sensor_nxt[SENS_B_EXIT] = (pos_b == PW'(EXIT_POS));
      w_sensor_nxt[SENS_A_EXIT] = (pos_a == PW'(EXIT_POS));
      w_sensor_nxt[SENS_SPARE]  = 1'b0;
   end

   // Collision is judged on the positions being loaded this edge, so the flag
   // rises together with the position that causes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sensor <= '0;
         r_coll   <= 1'b0;
      end else begin
         r_sensor <= w_sensor_nxt;
         r_coll   <= r_coll | (in_range(int'(w_a_nxt), SH_START, SH_END) &&
                               in_range(int'(w_b_nxt), SH_START, SH_END));
      end
   end

   assign sensor    = r_sensor;
   assign collision = r_coll;

endmodule

// File: tb/tb_train_track_model.sv
// Directed bench for train_track_model: a step-level track model checked every
// cycle, plus hand-computed expectations for the headline scenarios.
module tb_train_track_model;

   localparam int L = 16, S = 4, E = 7, T = 4;

   logic       clk;
   logic       rst;
   logic [2:0] sw;
   logic [1:0] dira, dirb;
   logic [4:0] sensor;
   logic [3:0] pos_a, pos_b;
   logic       derail_a, derail_b, collision;

   int n_cmp = 0;
   int n_bad = 0;

   train_track_model dut (
      .clk(clk), .rst(rst), .sw(sw), .dira(dira), .dirb(dirb),
      .sensor(sensor), .pos_a(pos_a), .pos_b(pos_b),
      .derail_a(derail_a), .derail_b(derail_b), .collision(collision)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int       ma, mb, mcnt;
   bit       mda, mdb, mcol;
   bit [4:0] msen;

   function automatic bit in_sh(input int p);
      return p >= S && p <= E;
   endfunction

   function automatic int delta(input logic [1:0] d);
      if (d == 2'b01) return 1;
      if (d == 2'b10) return -1;
      return 0;
   endfunction

   // A move that would carry the train from outside into the shared block
   // needs the switch; otherwise the train derails in place.
   task automatic advance(input int p, input int d, input bit ok, output int np, output bit der);
      int tgt;
      tgt = (p + d + L) % L;
      np  = p;
      der = 1'b0;
      if (d != 0 && in_sh(tgt) && !in_sh(p) && !ok) der = 1'b1;
      else np = tgt;
   endtask

   always @(posedge clk or posedge rst) begin : model
      int na, nb;
      bit da, db;
      bit [4:0] s;
      if (rst) begin
         ma <= 0; mb <= 10; mda <= 0; mdb <= 0; mcol <= 0; msen <= '0; mcnt <= 0;
      end else begin
         s = '0;
         s[0] = (ma == S - 1);
         s[1] = (mb == S - 1);
         s[2] = (mb == E + 1);
         s[3] = (ma == E + 1);
         na = ma; nb = mb; da = 0; db = 0;
         if (mcnt % T == T - 1) begin
            if (!mda) advance(ma, delta(dira), sw[1:0] == 2'b00, na, da);
            if (!mdb) advance(mb, delta(dirb), sw[1:0] == 2'b11, nb, db);
         end
         msen <= s;
         ma   <= na;
         mb   <= nb;
         mda  <= mda | da;
         mdb  <= mdb | db;
         mcol <= mcol | (in_sh(na) && in_sh(nb));
         mcnt <= mcnt + 1;
      end
   end

   always @(negedge clk) begin
      chk("pos_a", 32'(pos_a), 32'(ma));
      chk("pos_b", 32'(pos_b), 32'(mb));
      chk("sensor", 32'(sensor), 32'(msen));
      chk("derail_a", 32'(derail_a), 32'(mda));
      chk("derail_b", 32'(derail_b), 32'(mdb));
      chk("collision", 32'(collision), 32'(mcol));
   end

   // ---------------- stimulus ----------------
   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input logic [2:0] s, input logic [1:0] a, input logic [1:0] b);
      #2;
      rst = 1'b1; sw = s; dira = a; dirb = b;
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin : stim
      int owner;
      rst = 1'b1; sw = 3'b000; dira = 2'b00; dirb = 2'b00;
      #3;
      chk("reset_pos_a", 32'(pos_a), 32'd0);
      chk("reset_pos_b", 32'(pos_b), 32'd10);
      chk("reset_flags", 32'({derail_a, derail_b, collision}), 32'd0);
      chk("reset_sensor", 32'(sensor), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;

      // Both forward, switch set for A (sw[2] is don't-care).
      do_reset(3'b100, 2'b01, 2'b01);
      wait_edges(12);
      chk("t1_pos_a3", 32'(pos_a), 32'd3);
      chk("t1_sens_lag", 32'(sensor[0]), 32'd0);
      wait_edges(1);
      chk("t1_sens_a_app", 32'(sensor[0]), 32'd1);
      wait_edges(3);
      chk("t1_pos_a4", 32'(pos_a), 32'd4);
      chk("t1_pos_b14", 32'(pos_b), 32'd14);
      chk("t1_derail_b", 32'(derail_b), 32'd0);

      // Wrap: A reverse 0->15, B forward 15->0.
      do_reset(3'b000, 2'b10, 2'b01);
      wait_edges(4);
      chk("t2_a_wrap", 32'(pos_a), 32'd15);
      wait_edges(16);
      chk("t2_pos_b15", 32'(pos_b), 32'd15);
      wait_edges(4);
      chk("t2_b_wrap", 32'(pos_b), 32'd0);
      chk("t2_pos_a10", 32'(pos_a), 32'd10);
      chk("t2_flags", 32'({derail_a, derail_b, collision}), 32'd0);

      // Derail of A with the switch set for B.
      do_reset(3'b011, 2'b01, 2'b00);
      wait_edges(12);
      chk("t3_pos_a3", 32'(pos_a), 32'd3);
      wait_edges(4);
      chk("t3_held", 32'(pos_a), 32'd3);
      chk("t3_derail_a", 32'(derail_a), 32'd1);
      #2 dira = 2'b10;
      wait_edges(8);
      chk("t3_frozen", 32'(pos_a), 32'd3);
      chk("t3_sticky", 32'(derail_a), 32'd1);
      chk("t3_sensor", 32'(sensor), 32'd1);

      // Reset at tick count 2: immediate clear, first step TICK_DIV clocks on.
      wait_edges(2);
      #2 rst = 1'b1;
      #1;
      chk("t5_pos_a", 32'(pos_a), 32'd0);
      chk("t5_pos_b", 32'(pos_b), 32'd10);
      chk("t5_derail_a", 32'(derail_a), 32'd0);
      chk("t5_sensor", 32'(sensor), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      wait_edges(3);
      chk("t5_no_early", 32'(pos_a), 32'd0);
      wait_edges(1);
      chk("t5_first_step", 32'(pos_a), 32'd15);

      // Collision: A parked at 5, B routed into the shared block.
      do_reset(3'b000, 2'b01, 2'b01);
      wait_edges(20);
      chk("t4_pos_a5", 32'(pos_a), 32'd5);
      chk("t4_pos_b15", 32'(pos_b), 32'd15);
      #2 dira = 2'b00;
      wait_edges(16);
      chk("t4_pos_b3", 32'(pos_b), 32'd3);
      chk("t4_no_coll", 32'(collision), 32'd0);
      #2 sw = 3'b011;
      wait_edges(3);
      chk("t4_coll_early", 32'(collision), 32'd0);
      wait_edges(1);
      chk("t4_pos_b4", 32'(pos_b), 32'd4);
      chk("t4_coll", 32'(collision), 32'd1);
      wait_edges(8);
      chk("t4_b_moves", 32'(pos_b), 32'd6);
      chk("t4_coll_sticky", 32'(collision), 32'd1);
      chk("t4_no_derail", 32'({derail_a, derail_b}), 32'd0);

      // Closed loop: a token controller grants the shared block to one train.
      do_reset(3'b000, 2'b01, 2'b01);
      owner = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (owner == 1 && ma == E + 1) owner = 0;
         if (owner == 2 && mb == E + 1) owner = 0;
         if (owner == 0) begin
            if (ma == S - 1)      owner = 1;
            else if (mb == S - 1) owner = 2;
         end
         #2;
         sw   = (owner == 2) ? 3'b011 : 3'b000;
         dira = (ma == S - 1 && owner != 1) ? 2'b00 : 2'b01;
         dirb = (mb == S - 1 && owner != 2) ? 2'b00 : 2'b01;
      end
      @(negedge clk);
      chk("loop_flags", 32'({derail_a, derail_b, collision}), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/train_track_model.md
TRAIN_TRACK_MODEL -- requirements
Module: train_track_model

Interface
REQ-001 Parameters (name, default, meaning): LOOP_LEN 16, positions per loop; SH_START 4, first shared-segment position; SH_END 7, last shared-segment position; TICK_DIV 4, clocks per movement step; A_INIT 0, train A reset position; B_INIT 10, train B reset position.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sw  input  3  switch commands; sw[0]=sw[1]=1 routes shared segment to B, 0 routes to A; sw[2] ignored.
REQ-005 dira  input  2  train A motor: 01 forward, 10 reverse, 00/11 stop.
REQ-006 dirb  input  2  train B motor, same encoding as dira.
REQ-007 sensor  output  5  registered track sensors, bit map per REQ-013.
REQ-008 pos_a, pos_b  output  4 each  current train positions, 0..LOOP_LEN-1.
REQ-009 derail_a, derail_b  output  1 each  sticky derailment flags.
REQ-010 collision  output  1  sticky collision flag.

Function
REQ-011 Tick counter SHALL count 0..TICK_DIV-1 and wrap; a step occurs on the clock edge where count==TICK_DIV-1.
REQ-012 On a step, each non-derailed train SHALL move +1 (forward) or -1 (reverse) modulo LOOP_LEN, or hold (stop); wrap LOOP_LEN-1 -> 0 forward, 0 -> LOOP_LEN-1 reverse.
REQ-013 Sensor bits, computed from positions after update, registered (one clock after position change): [0] A at SH_START-1; [1] B at SH_START-1; [2] B at SH_END+1; [3] A at SH_END+1; [4] constant 0.
REQ-014 Switch is "set for A" when sw[1:0]==00, "set for B" when 11; 01/10 set for neither.
REQ-015 A forward step from SH_START-1 into SH_START with switch not set for A SHALL NOT move A and SHALL set derail_a; symmetric for B with derail_b; same rule for reverse entry from SH_END+1 into SH_END.
REQ-016 A derailed train SHALL remain frozen until reset regardless of its dir input.
REQ-017 collision SHALL set on the first clock where pos_a and pos_b are both within SH_START..SH_END; trains keep moving afterwards.
REQ-018 Simultaneous step of both trains SHALL use pre-step positions and pre-step switch for all checks; both derailments may set in the same step.
REQ-019 Switch changes between steps take effect at the next step only; no intra-step glitch on outputs.
REQ-020 Flags are sticky: once 1, stay 1 until reset.

Reset
REQ-021 rst asserted SHALL immediately force pos_a=A_INIT, pos_b=B_INIT, tick count 0, sensor=0, derail_a=derail_b=collision=0.
REQ-022 Reset mid-step SHALL discard the pending step; first step after release occurs TICK_DIV clocks after rst deasserts.
REQ-023 Every register SHALL be covered by rst; no initial-value reliance.

Structure
REQ-024 Shared package trainsim_pkg SHALL hold direction encodings (DIR_STOP, DIR_FWD, DIR_REV), sensor bit indices, and default track parameters, shared with the controller.
REQ-025 One sub-module train_mover (position register, wrap arithmetic, derail check, sticky flag) SHALL be instantiated twice, for A and B.
REQ-026 Top level contains only tick counter, switch decode, sensor register and collision logic; targeted size 120-400 RTL lines.

Verification
REQ-027 Reset release, dira=dirb=01, sw=000, 4 steps -> pos_a 0->4, pos_b 10->14, sensor[0]=1 one clock after pos_a==3, derail_b=0.
REQ-028 Wrap: B forward from 15 -> 0; A reverse from 0 -> 15; no flags set.
REQ-029 Derail: A at 3, sw=011, dira=01 -> on next step pos_a stays 3, derail_a=1, remains 1 after dira changes.
REQ-030 Collision: A at 5, B driven into 4 with sw=011 -> collision=1 that clock, stays 1.
REQ-031 Closed loop with trainsim controller plus LFSR-free stimulus, 2000 clocks -> derail_a=derail_b=collision=0 throughout.
REQ-032 Reset asserted at tick count 2 -> all outputs at reset values same clock; next step exactly TICK_DIV clocks after release.
